// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// router_pkg : shared types for the router local port (framing states, entry)
// Revision   : 1.0
// ============================================================================
package router_pkg;

    localparam int DEFAULT_FLIT_WIDTH = 32;

    typedef logic [DEFAULT_FLIT_WIDTH-1:0] flit_t;

    typedef enum logic [1:0] {
        ING_HEADER  = 2'd0,
        ING_SIZE    = 2'd1,
        ING_PAYLOAD = 2'd2
    } ing_state_t;

    typedef enum logic [1:0] {
        EG_HEADER  = 2'd0,
        EG_SIZE    = 2'd1,
        EG_PAYLOAD = 2'd2
    } eg_state_t;

    typedef struct packed {
        logic  last;
        flit_t flit;
    } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/router_local_port_if.sv
`default_nettype none
// ============================================================================
// router_local_port_if : DMA-side flit link plus crossbar inject/eject streams
// Revision             : 1.0
// ============================================================================
interface router_local_port_if #(
    parameter int FLIT_WIDTH = 32
);
    logic                  rx;
    logic [FLIT_WIDTH-1:0] data_i;
    logic                  credit_o;
    logic                  tx;
    logic [FLIT_WIDTH-1:0] data_o;
    logic                  credit_i;
    logic                  inj_valid;
    logic                  inj_ready;
    logic [FLIT_WIDTH-1:0] inj_data;
    logic                  inj_last;
    logic                  ej_valid;
    logic                  ej_ready;
    logic [FLIT_WIDTH-1:0] ej_data;

    modport slave (
        input  rx, data_i, credit_i, inj_ready, ej_valid, ej_data,
        output credit_o, tx, data_o, inj_valid, inj_data, inj_last, ej_ready
    );

    modport master (
        output rx, data_i, credit_i, inj_ready, ej_valid, ej_data,
        input  credit_o, tx, data_o, inj_valid, inj_data, inj_last, ej_ready
    );
endinterface
`default_nettype wire

// File: rtl/flit_fifo.sv
`default_nettype none
// ============================================================================
// flit_fifo : synchronous FIFO, wrapping pointers with a separate count
// Revision  : 1.0
// ============================================================================
module flit_fifo
    import router_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
    assign do_push  = push && (!full || pop);
    assign do_pop   = pop && !empty;
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/router_local_port.sv
`default_nettype none
// ============================================================================
// router_local_port : buffers and frames flits between the DMA and the crossbar
// Revision          : 1.0
// ============================================================================
module router_local_port
    import router_pkg::*;
#(
    parameter int FLIT_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 8,
    parameter int ADDRESS      = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clock_rx,
    router_local_port_if.slave  port,
    output logic                hdr_err
);
    localparam int CW = $clog2(BUFFER_DEPTH) + 1;
    localparam logic [FLIT_WIDTH-1:0] ADDR_FLIT = FLIT_WIDTH'(ADDRESS);

    typedef struct packed {
        logic                  last;
        logic [FLIT_WIDTH-1:0] flit;
    } inj_entry_t;

    // ---------------- injection path ----------------
    ing_state_t            ing_state, ing_state_next;
    logic [FLIT_WIDTH-1:0] ing_cnt, ing_cnt_next;
    logic                  ing_last;
    logic                  ing_wr;
    inj_entry_t            inj_wr_entry, inj_head;
    logic                  inj_full, inj_empty, inj_pop;
    logic [CW-1:0]         inj_count, inj_count_next;
    logic                  credit_q;

    assign inj_pop      = !inj_empty && port.inj_ready;
    assign ing_wr       = port.rx && (!inj_full || inj_pop);
    assign inj_wr_entry = '{last: ing_last, flit: port.data_i};

    flit_fifo #(.WIDTH(FLIT_WIDTH + 1), .DEPTH(BUFFER_DEPTH)) u_inject_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (ing_wr),
        .push_data (inj_wr_entry),
        .pop       (inj_pop),
        .pop_data  (inj_head),
        .full      (inj_full),
        .empty     (inj_empty),
        .count     (inj_count)
    );

    always_comb begin
        ing_state_next = ing_state;
        ing_cnt_next   = ing_cnt;
        ing_last       = 1'b0;
        if (ing_wr) begin
            case (ing_state)
                ING_HEADER: ing_state_next = ING_SIZE;
                ING_SIZE: begin
                    if (port.data_i == '0) begin
                        ing_last       = 1'b1;
                        ing_state_next = ING_HEADER;
                    end else begin
                        ing_cnt_next   = port.data_i;
                        ing_state_next = ING_PAYLOAD;
                    end
                end
                ING_PAYLOAD: begin
                    ing_cnt_next = ing_cnt - 1'b1;
                    if (ing_cnt == FLIT_WIDTH'(1)) begin
                        ing_last       = 1'b1;
                        ing_state_next = ING_HEADER;
                    end
                end
                default: ing_state_next = ING_HEADER;
            endcase
        end
    end

    always_comb begin
        inj_count_next = inj_count;
        if (ing_wr && !inj_pop)      inj_count_next = inj_count + 1'b1;
        else if (!ing_wr && inj_pop) inj_count_next = inj_count - 1'b1;
    end

    // Two free slots keep room for the flit the DMA launches after seeing credit drop.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ing_state <= ING_HEADER;
            ing_cnt   <= '0;
            credit_q  <= 1'b0;
        end else begin
            ing_state <= ing_state_next;
            ing_cnt   <= ing_cnt_next;
            credit_q  <= (inj_count_next <= CW'(BUFFER_DEPTH - 2));
        end
    end

    assign port.credit_o  = credit_q;
    assign port.inj_valid = !inj_empty;
    assign port.inj_data  = inj_head.flit;
    assign port.inj_last  = inj_head.last;

    // ---------------- ejection path ----------------
    eg_state_t             eg_state, eg_state_next;
    logic [FLIT_WIDTH-1:0] eg_cnt, eg_cnt_next;
    logic                  hdr_bad;
    logic                  ej_full, ej_empty, ej_ready_w, ej_wr, eg_pop;
    logic [FLIT_WIDTH-1:0] ej_head;
    logic [CW-1:0]         ej_count;
    logic                  tx_q;
    logic [FLIT_WIDTH-1:0] data_q;

    assign ej_ready_w = reset && !ej_full;
    assign ej_wr      = port.ej_valid && ej_ready_w;
    assign eg_pop     = tx_q && port.credit_i;

    flit_fifo #(.WIDTH(FLIT_WIDTH), .DEPTH(BUFFER_DEPTH)) u_eject_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (ej_wr),
        .push_data (port.ej_data),
        .pop       (eg_pop),
        .pop_data  (ej_head),
        .full      (ej_full),
        .empty     (ej_empty),
        .count     (ej_count)
    );

    always_comb begin
        eg_state_next = eg_state;
        eg_cnt_next   = eg_cnt;
        hdr_bad       = 1'b0;
        if (eg_pop) begin
            case (eg_state)
                EG_HEADER: begin
                    hdr_bad       = (data_q != ADDR_FLIT);
                    eg_state_next = EG_SIZE;
                end
                EG_SIZE: begin
                    if (data_q == '0) begin
                        eg_state_next = EG_HEADER;
                    end else begin
                        eg_cnt_next   = data_q;
                        eg_state_next = EG_PAYLOAD;
                    end
                end
                EG_PAYLOAD: begin
                    eg_cnt_next = eg_cnt - 1'b1;
                    if (eg_cnt == FLIT_WIDTH'(1)) eg_state_next = EG_HEADER;
                end
                default: eg_state_next = EG_HEADER;
            endcase
        end
    end

    // After each accepted flit tx drops for one cycle so a registered credit_i cannot re-accept.
    always_ff @(posedge clock) begin
        if (!reset) begin
            eg_state <= EG_HEADER;
            eg_cnt   <= '0;
            tx_q     <= 1'b0;
            data_q   <= '0;
            hdr_err  <= 1'b0;
        end else begin
            eg_state <= eg_state_next;
            eg_cnt   <= eg_cnt_next;
            if (hdr_bad) hdr_err <= 1'b1;
            if (tx_q) begin
                if (port.credit_i) tx_q <= 1'b0;
            end else if (!ej_empty) begin
                tx_q   <= 1'b1;
                data_q <= ej_head;
            end
        end
    end

    assign port.tx       = tx_q;
    assign port.data_o   = data_q;
    assign port.ej_ready = ej_ready_w;

    logic unused_signals;
    assign unused_signals = ^{clock_rx, ej_count};

endmodule
`default_nettype wire
